// File: rtl/grid_ctrl_pkg.sv
// grid_ctrl_pkg: shared encodings for the grid move sequencer
// Holds the direction codes, FSM state codes, winner codes and the opposite-direction helper.
package grid_ctrl_pkg;
  typedef enum logic [1:0] {UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11} dir_e;
  typedef enum logic [2:0] {INIT, IDLE, MOVE_A, MOVE_B, OVER} state_e;
  localparam logic [1:0] WIN_NONE = 2'b00, WIN_P1 = 2'b01, WIN_P2 = 2'b10, WIN_DRAW = 2'b11;
  // Reversals differ only in the low bit: up<->down, left<->right
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction
endpackage

// File: rtl/grid_step.sv
// grid_step: shifts a one-hot x/y location one cell in a direction and flags leaving the grid
// Ports: x_i/y_i current one-hot location, dir_i move direction,
//        x_o/y_o shifted location, off_grid_o high when either axis shifted out.
module grid_step import grid_ctrl_pkg::*; #(
  parameter int W = 32,
  parameter int H = 32
) (
  input  logic [W-1:0] x_i,
  input  logic [H-1:0] y_i,
  input  dir_e         dir_i,
  output logic [W-1:0] x_o,
  output logic [H-1:0] y_o,
  output logic         off_grid_o
);
  assign x_o = dir_i == LEFT ? x_i >> 1 : dir_i == RIGHT ? x_i << 1 : x_i;
  assign y_o = dir_i == UP ? y_i >> 1 : dir_i == DOWN ? y_i << 1 : y_i;
  assign off_grid_o = ~|x_o || ~|y_o;
endmodule

// File: rtl/grid_move_sequencer.sv
// grid_move_sequencer: sequences per-tick player moves into the grid register bank
// Ports: clock_i/reset_i (sync, active-high), tick_i move strobe, restart_i leaves OVER,
//        pN_req_i/pN_dir_i/pN_ack_o direction handshake, loc_pN_x/y_i current grid locations,
//        enable1/2_o grid write enables, nxt_loc/nxt_wall_x/y_o shared write bus,
//        game_over_o and winner_o to the score/display logic.
module grid_move_sequencer import grid_ctrl_pkg::*; #(
  parameter int gridWidth  = 32,
  parameter int gridHeight = 32,
  parameter int P1_START_X = 2,
  parameter int P1_START_Y = 16,
  parameter int P2_START_X = 29,
  parameter int P2_START_Y = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  tick_i,
  input  logic                  restart_i,
  input  logic                  p1_req_i,
  input  logic                  p2_req_i,
  input  logic [1:0]            p1_dir_i,
  input  logic [1:0]            p2_dir_i,
  output logic                  p1_ack_o,
  output logic                  p2_ack_o,
  input  logic [gridWidth-1:0]  loc_p1_x_i,
  input  logic [gridWidth-1:0]  loc_p2_x_i,
  input  logic [gridHeight-1:0] loc_p1_y_i,
  input  logic [gridHeight-1:0] loc_p2_y_i,
  output logic                  enable1_o,
  output logic                  enable2_o,
  output logic [gridWidth-1:0]  nxt_loc_x_o,
  output logic [gridWidth-1:0]  nxt_wall_x_o,
  output logic [gridHeight-1:0] nxt_loc_y_o,
  output logic [gridHeight-1:0] nxt_wall_y_o,
  output logic                  game_over_o,
  output logic [1:0]            winner_o
);
  localparam logic [gridWidth-1:0] ONE_X = gridWidth'(1);
  localparam logic [gridHeight-1:0] ONE_Y = gridHeight'(1);
  localparam logic [gridWidth-1:0] P1_X = ONE_X << P1_START_X;
  localparam logic [gridWidth-1:0] P2_X = ONE_X << P2_START_X;
  localparam logic [gridHeight-1:0] P1_Y = ONE_Y << P1_START_Y;
  localparam logic [gridHeight-1:0] P2_Y = ONE_Y << P2_START_Y;
  state_e state_q, state_d;
  dir_e dir1_q, dir1_d, dir2_q, dir2_d, step_dir;
  logic first_p2_q, first_p2_d, init2_q, crash1_q, crash1_d, crash2_q, crash2_d;
  logic en1_q, en2_q, ack1_q, ack1_d, ack2_q, ack2_d, over_q;
  logic accept, moving, mover_p2, off_grid, crash, init1;
  logic [1:0] win_q, win_d;
  logic [gridWidth-1:0] loc_x_q, loc_x_d, wall_x_q, wall_x_d, cur_x, opp_x, step_x;
  logic [gridHeight-1:0] loc_y_q, loc_y_d, wall_y_q, wall_y_d, cur_y, opp_y, step_y;
  // The cycle that writes P2's start location is still part of initialisation
  assign accept = state_q == IDLE && !init2_q;
  assign init1 = state_q == INIT;
  always_comb begin
    state_d = state_q == INIT   ? IDLE
            : state_q == IDLE   ? (accept && tick_i ? MOVE_A : IDLE)
            : state_q == MOVE_A ? MOVE_B
            : state_q == MOVE_B ? (crash1_q || crash2_q ? OVER : IDLE)
            : restart_i         ? INIT : OVER;
  end
  assign ack1_d = accept && p1_req_i && !ack1_q;
  assign ack2_d = accept && p2_req_i && !ack2_q;
  assign dir1_d = state_d == INIT ? RIGHT
                : (ack1_d && dir_e'(p1_dir_i) != opposite(dir1_q)) ? dir_e'(p1_dir_i) : dir1_q;
  assign dir2_d = state_d == INIT ? LEFT
                : (ack2_d && dir_e'(p2_dir_i) != opposite(dir2_q)) ? dir_e'(p2_dir_i) : dir2_q;
  // Outputs are registered against the state being entered, so the mover is chosen from state_d
  assign moving = state_d == MOVE_A || state_d == MOVE_B;
  assign mover_p2 = first_p2_q ^ (state_d == MOVE_B);
  assign cur_x = mover_p2 ? loc_p2_x_i : loc_p1_x_i;
  assign cur_y = mover_p2 ? loc_p2_y_i : loc_p1_y_i;
  assign step_dir = mover_p2 ? dir2_d : dir1_d;
  // The grid has not yet latched the first mover when MOVE_B is computed; use the value being written
  assign opp_x = state_q == MOVE_A ? loc_x_q : mover_p2 ? loc_p1_x_i : loc_p2_x_i;
  assign opp_y = state_q == MOVE_A ? loc_y_q : mover_p2 ? loc_p1_y_i : loc_p2_y_i;
  grid_step #(.W(gridWidth), .H(gridHeight)) u_step (
    .x_i(cur_x), .y_i(cur_y), .dir_i(step_dir),
    .x_o(step_x), .y_o(step_y), .off_grid_o(off_grid)
  );
  assign crash = moving && (off_grid || (step_x == opp_x && step_y == opp_y));
  assign crash1_d = state_d != INIT && (crash1_q || (crash && !mover_p2));
  assign crash2_d = state_d != INIT && (crash2_q || (crash && mover_p2));
  assign first_p2_d = state_d != INIT && (first_p2_q ^ (state_q == MOVE_B && state_d == IDLE));
  assign loc_x_d = init1 ? P1_X : init2_q ? P2_X : moving ? step_x : '0;
  assign loc_y_d = init1 ? P1_Y : init2_q ? P2_Y : moving ? step_y : '0;
  assign wall_x_d = init1 ? P1_X : init2_q ? P2_X : moving ? cur_x : '0;
  assign wall_y_d = init1 ? P1_Y : init2_q ? P2_Y : moving ? cur_y : '0;
  assign win_d = state_d != OVER ? WIN_NONE
               : crash1_q && crash2_q ? WIN_DRAW
               : crash1_q ? WIN_P2 : crash2_q ? WIN_P1 : WIN_NONE;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= INIT;
      dir1_q <= RIGHT;
      dir2_q <= LEFT;
      first_p2_q <= 1'b0;
      init2_q <= 1'b0;
      crash1_q <= 1'b0;
      crash2_q <= 1'b0;
      en1_q <= 1'b0;
      en2_q <= 1'b0;
      ack1_q <= 1'b0;
      ack2_q <= 1'b0;
      over_q <= 1'b0;
      win_q <= WIN_NONE;
      loc_x_q <= '0;
      loc_y_q <= '0;
      wall_x_q <= '0;
      wall_y_q <= '0;
    end else begin
      state_q <= state_d;
      dir1_q <= dir1_d;
      dir2_q <= dir2_d;
      first_p2_q <= first_p2_d;
      init2_q <= init1;
      crash1_q <= crash1_d;
      crash2_q <= crash2_d;
      en1_q <= init1 || (moving && !mover_p2);
      en2_q <= init2_q || (moving && mover_p2);
      ack1_q <= ack1_d;
      ack2_q <= ack2_d;
      over_q <= state_d == OVER;
      win_q <= win_d;
      loc_x_q <= loc_x_d;
      loc_y_q <= loc_y_d;
      wall_x_q <= wall_x_d;
      wall_y_q <= wall_y_d;
    end
  end
  assign p1_ack_o = ack1_q;
  assign p2_ack_o = ack2_q;
  assign enable1_o = en1_q;
  assign enable2_o = en2_q;
  assign nxt_loc_x_o = loc_x_q;
  assign nxt_loc_y_o = loc_y_q;
  assign nxt_wall_x_o = wall_x_q;
  assign nxt_wall_y_o = wall_y_q;
  assign game_over_o = over_q;
  assign winner_o = win_q;
endmodule

// File: tb/tb_grid_move_sequencer.sv
// tb_grid_move_sequencer: scoreboard bench with a behavioural grid register bank
module tb_grid_move_sequencer;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, restart = 1'b0, p1_req = 1'b0, p2_req = 1'b0;
  logic [1:0] p1_dir = 2'b00, p2_dir = 2'b00, winner;
  logic p1_ack, p2_ack, en1, en2, game_over;
  logic [31:0] g1x = '0, g1y = '0, g2x = '0, g2y = '0, nlx, nly, nwx, nwy;
  logic poke = 1'b0;
  logic [31:0] px1 = '0, py1 = '0, px2 = '0, py2 = '0;
  int cnt = 0, n_cmp = 0, n_bad = 0;
  typedef struct {logic [1:0] en; logic [31:0] lx, ly, wx, wy; int at;} wr_t;
  typedef struct {logic [1:0] ack; int at;} ak_t;
  wr_t wq[$];
  ak_t aq[$];
  wr_t we;
  ak_t ae;
  grid_move_sequencer dut (
    .clock_i(clk), .reset_i(rst), .tick_i(tick), .restart_i(restart),
    .p1_req_i(p1_req), .p2_req_i(p2_req), .p1_dir_i(p1_dir), .p2_dir_i(p2_dir),
    .p1_ack_o(p1_ack), .p2_ack_o(p2_ack),
    .loc_p1_x_i(g1x), .loc_p2_x_i(g2x), .loc_p1_y_i(g1y), .loc_p2_y_i(g2y),
    .enable1_o(en1), .enable2_o(en2),
    .nxt_loc_x_o(nlx), .nxt_wall_x_o(nwx), .nxt_loc_y_o(nly), .nxt_wall_y_o(nwy),
    .game_over_o(game_over), .winner_o(winner)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;
  // Grid register bank: latches the shared bus on each enable, or takes a directed placement
  always @(posedge clk) begin
    if (poke) begin
      g1x <= px1; g1y <= py1; g2x <= px2; g2y <= py2;
    end else begin
      if (en1) begin g1x <= nlx; g1y <= nly; end
      if (en2) begin g2x <= nlx; g2y <= nly; end
    end
  end
  always @(negedge clk) begin
    if (en1 || en2) begin
      n_cmp++;
      if (wq.size() == 0) begin
        n_bad++;
        $display("FAIL write_unexpected cycle=%0d en=%b loc=%h/%h", cnt, {en2, en1}, nlx, nly);
      end else begin
        we = wq.pop_front();
        if ({en2, en1} !== we.en || nlx !== we.lx || nly !== we.ly || nwx !== we.wx || nwy !== we.wy || cnt != we.at) begin
          n_bad++;
          $display("FAIL write cycle=%0d en=%b loc=%h/%h wall=%h/%h, expected cycle=%0d en=%b loc=%h/%h wall=%h/%h",
                   cnt, {en2, en1}, nlx, nly, nwx, nwy, we.at, we.en, we.lx, we.ly, we.wx, we.wy);
        end
      end
    end else if (wq.size() != 0 && wq[0].at <= cnt) begin
      n_cmp++;
      n_bad++;
      we = wq.pop_front();
      $display("FAIL write_missing cycle=%0d no enable, expected en=%b loc=%h/%h", cnt, we.en, we.lx, we.ly);
    end
  end
  always @(negedge clk) begin
    if (p1_ack || p2_ack) begin
      n_cmp++;
      if (aq.size() == 0) begin
        n_bad++;
        $display("FAIL ack_unexpected cycle=%0d ack=%b", cnt, {p2_ack, p1_ack});
      end else begin
        ae = aq.pop_front();
        if ({p2_ack, p1_ack} !== ae.ack || cnt != ae.at) begin
          n_bad++;
          $display("FAIL ack cycle=%0d ack=%b, expected cycle=%0d ack=%b", cnt, {p2_ack, p1_ack}, ae.at, ae.ack);
        end
      end
    end else if (aq.size() != 0 && aq[0].at <= cnt) begin
      n_cmp++;
      n_bad++;
      ae = aq.pop_front();
      $display("FAIL ack_missing cycle=%0d, expected ack=%b", cnt, ae.ack);
    end
  end
  function automatic logic [31:0] oh(input int b);
    return 32'd1 << b;
  endfunction
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic push_init(input int d);
    wq.push_back('{2'b01, oh(2), oh(16), oh(2), oh(16), cnt + d});
    wq.push_back('{2'b10, oh(29), oh(16), oh(29), oh(16), cnt + d + 1});
  endtask
  task automatic tick_move(input bit p2f, input logic [31:0] ax, ay, awx, awy, bx, by, bwx, bwy);
    wr_t e1, e2;
    e1 = '{2'b01, ax, ay, awx, awy, cnt + (p2f ? 2 : 1)};
    e2 = '{2'b10, bx, by, bwx, bwy, cnt + (p2f ? 1 : 2)};
    if (p2f) begin wq.push_back(e2); wq.push_back(e1); end
    else begin wq.push_back(e1); wq.push_back(e2); end
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(2);
  endtask
  task automatic req(input bit r1, input bit r2, input logic [1:0] d1, input logic [1:0] d2);
    aq.push_back('{{r2, r1}, cnt + 1});
    p1_req = r1; p2_req = r2; p1_dir = d1; p2_dir = d2;
    step(1);
    p1_req = 1'b0; p2_req = 1'b0;
  endtask
  task automatic place(input logic [31:0] a, b, c, d);
    px1 = a; py1 = b; px2 = c; py2 = d;
    poke = 1'b1;
    step(1);
    poke = 1'b0;
  endtask
  task automatic do_restart(input bit with_tick);
    push_init(2);
    restart = 1'b1;
    tick = with_tick;
    step(1);
    restart = 1'b0;
    tick = 1'b0;
    step(3);
    check("restart_winner", 32'(winner), 32'd0);
    check("restart_game_over", 32'(game_over), 32'd0);
  endtask
  initial begin
    step(2);
    check("rst_enables", 32'({en2, en1}), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_nxt_loc_x", nlx, 32'd0);
    push_init(1);
    rst = 1'b0;
    step(4);
    check("init_p1_x", g1x, oh(2));
    check("init_p1_y", g1y, oh(16));
    check("init_p2_x", g2x, oh(29));
    check("init_p2_y", g2y, oh(16));
    check("init_winner", 32'(winner), 32'd0);
    tick_move(0, oh(3), oh(16), oh(2), oh(16), oh(28), oh(16), oh(29), oh(16));
    tick_move(1, oh(4), oh(16), oh(3), oh(16), oh(27), oh(16), oh(28), oh(16));
    req(1, 0, 2'b00, 2'b00);
    tick_move(0, oh(4), oh(15), oh(4), oh(16), oh(26), oh(16), oh(27), oh(16));
    req(1, 1, 2'b10, 2'b11);
    tick_move(1, oh(3), oh(15), oh(4), oh(15), oh(25), oh(16), oh(26), oh(16));
    wq.push_back('{2'b01, oh(2), oh(15), oh(3), oh(15), cnt + 1});
    wq.push_back('{2'b10, oh(24), oh(16), oh(25), oh(16), cnt + 2});
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    check("midmove_rst_enables", 32'({en2, en1}), 32'd0);
    check("midmove_rst_nxt_loc_x", nlx, 32'd0);
    step(1);
    push_init(1);
    rst = 1'b0;
    step(4);
    tick_move(0, oh(3), oh(16), oh(2), oh(16), oh(28), oh(16), oh(29), oh(16));
    req(1, 0, 2'b00, 2'b00);
    for (int k = 1; k <= 17; k++)
      tick_move(k % 2 == 1, oh(3), k <= 16 ? oh(16 - k) : 32'd0, oh(3), oh(17 - k),
                oh(28 - k), oh(16), oh(29 - k), oh(16));
    check("offgrid_game_over", 32'(game_over), 32'd1);
    check("offgrid_winner", 32'(winner), 32'd2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(4);
    check("over_tick_ignored", 32'(game_over), 32'd1);
    check("over_winner_held", 32'(winner), 32'd2);
    do_restart(1);
    place(oh(10), oh(16), oh(12), oh(16));
    tick_move(0, oh(11), oh(16), oh(10), oh(16), oh(11), oh(16), oh(12), oh(16));
    check("collide_game_over", 32'(game_over), 32'd1);
    check("collide_winner", 32'(winner), 32'd1);
    do_restart(0);
    place(oh(31), oh(5), oh(0), oh(20));
    tick_move(0, 32'd0, oh(5), oh(31), oh(5), 32'd0, oh(20), oh(0), oh(20));
    check("draw_game_over", 32'(game_over), 32'd1);
    check("draw_winner", 32'(winner), 32'd3);
    step(3);
    check("write_queue_left", 32'(wq.size()), 32'd0);
    check("ack_queue_left", 32'(aq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d did not finish", cnt);
    $fatal(1, "watchdog");
  end
endmodule
